pid_incr: RTL and testbench

Parametrised incremental (velocity-form) PID controller with shift-based gains, a programmable update prescaler, output clamping and an optional derivative term. It sits between the error-computation stage (setpoint minus measured current) and the actuator/PWM driver. Each update runs through a four-state pipeline and produces one clamped control word with a valid strobe.

---
 rtl/pid_incr.sv | 219 +++++++++++++++++++++
 tb/tb_pid_incr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_incr.sv
// pid_incr: incremental (velocity-form) PID controller with shift-based gains,
// a programmable update prescaler and output clamping. Each prescaler tick
// runs IDLE -> DIFF -> SUM -> CLAMP and produces one clamped control word.
// Define PID_DERIV_EN to build the derivative (second-difference) term.
module pid_incr #(
  parameter int W     = 16,
  parameter int DIV_W = 16,
  parameter int SH_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic [DIV_W-1:0]    div,
  input  logic signed [W-1:0] e_in,
  input  logic [SH_W-1:0]     kp_sh,
  input  logic [SH_W-1:0]     ki_sh,
  input  logic [SH_W-1:0]     kd_sh,
  input  logic signed [W-1:0] u_min,
  input  logic signed [W-1:0] u_max,
  output logic signed [W-1:0] u_out,
  output logic                u_valid,
  output logic                sat,
  output logic                overrun
);

`ifdef PID_DERIV_EN
  localparam int AW = W + 4;
`else
  localparam int AW = W + 3;
`endif

  // All-ones shift code switches a term off entirely.
  localparam logic [SH_W-1:0] SH_OFF = '1;

  typedef enum logic [1:0] {IDLE, DIFF, SUM, CLAMP} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic signed [W-1:0]   e_s_q, e_s_d;
  logic signed [W-1:0]   e1_q, e1_d;
  logic signed [W:0]     d1_q, d1_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [W-1:0]   u_out_q, u_out_d;
  logic                  u_valid_q, u_valid_d;
  logic                  sat_q, sat_d;
  logic                  overrun_q, overrun_d;
  logic                  tick;

`ifdef PID_DERIV_EN
  logic signed [W-1:0]   e2_q, e2_d;
  logic signed [W+1:0]   d2_q, d2_d;
  logic signed [AW-1:0]  d_x;
`else
  logic                  unused_kd;
  assign unused_kd = ^kd_sh;
`endif

  logic signed [AW-1:0]  p_x, i_x, u_x, lo_x, hi_x;
  logic signed [AW-1:0]  p_term, i_term, d_term, sum;

  assign u_out   = u_out_q;
  assign u_valid = u_valid_q;
  assign sat     = sat_q;
  assign overrun = overrun_q;

  // Prescaler: free-running while en, one tick every div+1 cycles.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q >= div) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (clr) begin
      cnt_d = '0;
    end
  end

  // Gain terms: sign-extend to accumulator width, then floor-shift (or zero).
  always_comb begin
    p_x    = {{(AW-W-1){d1_q[W]}}, d1_q};
    i_x    = {{(AW-W){e_s_q[W-1]}}, e_s_q};
    u_x    = {{(AW-W){u_out_q[W-1]}}, u_out_q};
    lo_x   = {{(AW-W){u_min[W-1]}}, u_min};
    hi_x   = {{(AW-W){u_max[W-1]}}, u_max};
    p_term = '0;
    i_term = '0;
    d_term = '0;
    if (kp_sh != SH_OFF) begin
      p_term = p_x >>> kp_sh;
    end
    if (ki_sh != SH_OFF) begin
      i_term = i_x >>> ki_sh;
    end
`ifdef PID_DERIV_EN
    d_x = {{(AW-W-2){d2_q[W+1]}}, d2_q};
    if (kd_sh != SH_OFF) begin
      d_term = d_x >>> kd_sh;
    end
`endif
    sum = u_x + p_term + i_term + d_term;
  end

  // Update pipeline and flags; clr overrides everything.
  always_comb begin
    state_d   = state_q;
    e_s_d     = e_s_q;
    e1_d      = e1_q;
    d1_d      = d1_q;
    acc_d     = acc_q;
    u_out_d   = u_out_q;
    u_valid_d = 1'b0;
    sat_d     = sat_q;
    overrun_d = overrun_q;
`ifdef PID_DERIV_EN
    e2_d      = e2_q;
    d2_d      = d2_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick) begin
          e_s_d   = e_in;
          state_d = DIFF;
        end
      end
      DIFF: begin
        d1_d = {e_s_q[W-1], e_s_q} - {e1_q[W-1], e1_q};
`ifdef PID_DERIV_EN
        d2_d = {{2{e_s_q[W-1]}}, e_s_q} - {e1_q[W-1], e1_q, 1'b0}
             + {{2{e2_q[W-1]}}, e2_q};
`endif
        state_d = SUM;
      end
      SUM: begin
        acc_d   = sum;
        state_d = CLAMP;
      end
      default: begin
        // Inverted limits resolve to u_min.
        if ((u_min > u_max) || (acc_q < lo_x)) begin
          u_out_d = u_min;
          sat_d   = 1'b1;
        end else if (acc_q > hi_x) begin
          u_out_d = u_max;
          sat_d   = 1'b1;
        end else begin
          u_out_d = acc_q[W-1:0];
          sat_d   = 1'b0;
        end
`ifdef PID_DERIV_EN
        e2_d = e1_q;
`endif
        e1_d      = e_s_q;
        u_valid_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
    // A tick that finds an update in flight is dropped and flagged.
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    if (clr) begin
      state_d   = IDLE;
      e_s_d     = '0;
      e1_d      = '0;
      d1_d      = '0;
      acc_d     = '0;
      u_out_d   = '0;
      u_valid_d = 1'b0;
      sat_d     = 1'b0;
      overrun_d = 1'b0;
`ifdef PID_DERIV_EN
      e2_d      = '0;
      d2_d      = '0;
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      e_s_q     <= '0;
      e1_q      <= '0;
      d1_q      <= '0;
      acc_q     <= '0;
      u_out_q   <= '0;
      u_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PID_DERIV_EN
      e2_q      <= '0;
      d2_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e_s_q     <= e_s_d;
      e1_q      <= e1_d;
      d1_q      <= d1_d;
      acc_q     <= acc_d;
      u_out_q   <= u_out_d;
      u_valid_q <= u_valid_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
`ifdef PID_DERIV_EN
      e2_q      <= e2_d;
      d2_q      <= d2_d;
`endif
    end
  end

endmodule

// File: tb/tb_pid_incr.sv
// Testbench for pid_incr: directed scenarios plus randomized updates checked
// against an arithmetic reference model of the velocity-form PID law.
module tb_pid_incr;
  localparam int W     = 16;
  localparam int DIV_W = 16;
  localparam int SH_W  = 4;
  localparam int OFF   = (1 << SH_W) - 1;
`ifdef PID_DERIV_EN
  localparam bit DERIV = 1'b1;
`else
  localparam bit DERIV = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset, clr, en;
  logic [DIV_W-1:0]    div;
  logic signed [W-1:0] e_in, u_min, u_max, u_out;
  logic [SH_W-1:0]     kp_sh, ki_sh, kd_sh;
  logic                u_valid, sat, overrun;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint m_u, m_e1, m_e2, exp_u;
  bit     exp_sat, sat_known;

  always #5 clk = ~clk;

  pid_incr #(.W(W), .DIV_W(DIV_W), .SH_W(SH_W)) dut (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .div(div), .e_in(e_in),
    .kp_sh(kp_sh), .ki_sh(ki_sh), .kd_sh(kd_sh), .u_min(u_min), .u_max(u_max),
    .u_out(u_out), .u_valid(u_valid), .sat(sat), .overrun(overrun)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Floor division by 2^sh; the off code yields zero.
  function automatic longint fshift(input longint x, input int sh);
    longint p, q;
    if (sh == OFF) return 0;
    p = longint'(1) << sh;
    q = x / p;
    if ((x % p != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: one PID update from the sample e_in and current gains/limits.
  task automatic model_update();
    longint e, d1, d2, acc, lo, hi;
    e   = longint'(e_in);
    lo  = longint'(u_min);
    hi  = longint'(u_max);
    d1  = e - m_e1;
    d2  = DERIV ? (e - 2 * m_e1 + m_e2) : 0;
    acc = m_u + fshift(d1, int'(kp_sh)) + fshift(e, int'(ki_sh))
        + (DERIV ? fshift(d2, int'(kd_sh)) : 0);
    sat_known = 1'b1;
    if (lo > hi) begin
      exp_u = lo; sat_known = 1'b0;
    end else if (acc > hi) begin
      exp_u = hi; exp_sat = 1'b1;
    end else if (acc < lo) begin
      exp_u = lo; exp_sat = 1'b1;
    end else begin
      exp_u = acc; exp_sat = 1'b0;
    end
    m_e2 = m_e1;
    m_e1 = e;
    m_u  = exp_u;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (u_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic expect_update(input string tag, input longint eu, input int es);
    bit ok; int cyc;
    wait_valid(40, ok, cyc);
    check({tag, "_valid_seen"}, ok, 1);
    check({tag, "_u_out"}, u_out, eu);
    if (es >= 0) check({tag, "_sat"}, sat, es);
    $display("update %-10s u_out=%0d sat=%0b overrun=%0b", tag, u_out, sat, overrun);
  endtask

  // Apply settings, pulse clr for one cycle; returns #1 after the clr edge.
  task automatic setup(input int d, input int kp, input int ki, input int kd,
                       input int lo, input int hi, input int e);
    div = DIV_W'(d); kp_sh = SH_W'(kp); ki_sh = SH_W'(ki); kd_sh = SH_W'(kd);
    u_min = W'(lo); u_max = W'(hi); e_in = W'(e); en = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    m_u = 0; m_e1 = 0; m_e2 = 0;
  endtask

  initial begin
    bit ok; int cyc, nv;
    reset = 1'b1; clr = 1'b0; en = 1'b0; div = '0; e_in = '0;
    kp_sh = '1; ki_sh = '1; kd_sh = '1; u_min = '0; u_max = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_u_out", u_out, 0);
    check("rst_u_valid", u_valid, 0);
    check("rst_sat", sat, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Proportional
    setup(3, 0, OFF, OFF, -1000, 1000, 100);
    expect_update("prop1", 100, 0);
    @(posedge clk); #1;
    check("prop_valid_pulse", u_valid, 0);
    expect_update("prop2", 100, 0);
    expect_update("prop3", 100, 0);

    // Asynchronous reset mid-SUM, then first update timing after release
    @(posedge clk); #1;               // one cycle after u_valid (DIFF)
    @(posedge clk); #2;               // SUM
    reset = 1'b1;
    #1;
    check("async_rst_u_out", u_out, 0);
    check("async_rst_u_valid", u_valid, 0);
    check("async_rst_overrun", overrun, 0);
    @(negedge clk) reset = 1'b0;
    wait_valid(40, ok, cyc);
    check("post_rst_valid_seen", ok, 1);
    check("post_rst_latency", cyc, 3 + 4);
    check("post_rst_u_out", u_out, 100);
    $display("reset: first update %0d cycles after release u_out=%0d", cyc, u_out);

    // Integral
    setup(3, OFF, 2, OFF, -1000, 1000, 100);
    expect_update("int1", 25, 0);
    expect_update("int2", 50, 0);
    expect_update("int3", 75, 0);
    expect_update("int4", 100, 0);

    // Saturation and anti-windup
    setup(3, OFF, 2, OFF, -1000, 60, 100);
    expect_update("sat1", 25, 0);
    expect_update("sat2", 50, 0);
    expect_update("sat3", 60, 1);
    expect_update("sat4", 60, 1);
    e_in = -16'sd100;
    expect_update("unwind", 35, 0);

    // Overrun with div = 1
    setup(1, 0, OFF, OFF, -1000, 1000, 100);
    check("ovr_cleared", overrun, 0);
    expect_update("ovr1", 100, 0);
    check("ovr_set", overrun, 1);
    for (int k = 0; k < 3; k++) begin
      wait_valid(40, ok, cyc);
      check("ovr_valid_seen", ok, 1);
      check("ovr_valid_spacing", cyc, 4);
      check("ovr_sticky", overrun, 1);
      $display("overrun: u_valid after %0d cycles overrun=%0b", cyc, overrun);
    end
    setup(3, 0, OFF, OFF, -1000, 1000, 100);
    check("ovr_clr", overrun, 0);

    // en low stops new updates
    en = 1'b0;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (u_valid === 1'b1) nv++;
    end
    check("en_low_no_updates", nv, 0);
    en = 1'b1;
    expect_update("en_resume", 100, 0);

    // Derivative step response
    setup(3, OFF, OFF, 0, -1000, 1000, 0);
    expect_update("der0", 0, 0);
    e_in = 16'sd100;
    expect_update("der1", DERIV ? 100 : 0, 0);
    expect_update("der2", 0, 0);
    expect_update("der3", 0, 0);

    // Randomized updates against the reference model
    setup(3, $urandom_range(0, OFF), $urandom_range(0, OFF), $urandom_range(0, OFF),
          -32768, 32767, int'($urandom_range(0, 65535)) - 32768);
    for (int k = 0; k < 40; k++) begin
      int a, b;
      wait_valid(40, ok, cyc);
      check("rnd_valid_seen", ok, 1);
      model_update();
      check("rnd_u_out", u_out, exp_u);
      if (sat_known) check("rnd_sat", sat, exp_sat);
      $display("rnd %0d: u_out=%0d exp=%0d sat=%0b", k, u_out, exp_u, sat);
      e_in  = W'($urandom_range(0, 65535));
      kp_sh = SH_W'($urandom_range(0, OFF));
      ki_sh = SH_W'($urandom_range(0, OFF));
      kd_sh = SH_W'($urandom_range(0, OFF));
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 1) == 0) begin
        a = -32768; b = 32767;
      end
      if ((a > b) == ($urandom_range(0, 7) != 0)) begin
        int t; t = a; a = b; b = t;
      end
      u_min = W'(a);
      u_max = W'(b);
    end
    check("rnd_no_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
